// File: rtl/core_types_pkg.sv
// Shared front-end types and sizing for the return address stack.
package core_types_pkg;

    localparam int unsigned RAS_ENTRIES      = 8;
    localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
    localparam int unsigned RAS_TARGET_WIDTH = 31;
    localparam logic [31:0] INIT_PC          = 32'h0;

    typedef logic [RAS_TARGET_WIDTH-1:0] ras_target_t;

    // Entries hold PC[31:1]; bit 0 of a return address is always zero.
    localparam ras_target_t INIT_TARGET = INIT_PC[31:1];

endpackage

// File: rtl/ras_stack.sv
// Circular return address stack with checkpoint restore of pointer and count.
// Optional build macro: RAS_UNDERFLOW_PROTECT_EN (pop on empty leaves the pointer alone).
module ras_stack
    import core_types_pkg::*;
(
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push_valid,
    input  ras_target_t                push_target,
    input  logic                       pop_valid,
    input  logic                       restore_valid,
    input  logic [RAS_INDEX_WIDTH-1:0] restore_index,
    input  logic [RAS_INDEX_WIDTH:0]   restore_count,
    output ras_target_t                ras_ret_target,
    output logic [RAS_INDEX_WIDTH-1:0] ras_index,
    output logic [RAS_INDEX_WIDTH:0]   ras_count,
    output logic                       ras_empty
);

    localparam logic [RAS_INDEX_WIDTH:0]   FULL_COUNT = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);
    localparam logic [RAS_INDEX_WIDTH-1:0] PTR_ONE    = RAS_INDEX_WIDTH'(1);
    localparam logic [RAS_INDEX_WIDTH:0]   CNT_ONE    = (RAS_INDEX_WIDTH+1)'(1);

    ras_target_t                mem_q [RAS_ENTRIES];
    logic [RAS_INDEX_WIDTH-1:0] ptr_q, ptr_d;
    logic [RAS_INDEX_WIDTH:0]   count_q, count_d;
    logic                       wr_en;
    logic [RAS_INDEX_WIDTH-1:0] wr_idx;
    logic                       cnt_zero;

    assign cnt_zero = (count_q == '0);

    // Pointer, occupancy and write-port next state; restore overrides push/pop.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = ptr_q;
        if (restore_valid) begin
            ptr_d   = restore_index;
            count_d = restore_count;
        end else if (push_valid && pop_valid) begin
`ifdef RAS_UNDERFLOW_PROTECT_EN
            if (cnt_zero) begin
                ptr_d   = ptr_q + PTR_ONE;
                count_d = CNT_ONE;
                wr_idx  = ptr_q + PTR_ONE;
            end
            wr_en = 1'b1;
`else
            wr_en = 1'b1;
`endif
        end else if (push_valid) begin
            ptr_d   = ptr_q + PTR_ONE;
            wr_en   = 1'b1;
            wr_idx  = ptr_q + PTR_ONE;
            count_d = (count_q == FULL_COUNT) ? count_q : count_q + CNT_ONE;
        end else if (pop_valid) begin
`ifdef RAS_UNDERFLOW_PROTECT_EN
            if (!cnt_zero) begin
                ptr_d   = ptr_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end
`else
            ptr_d   = ptr_q - PTR_ONE;
            count_d = cnt_zero ? count_q : count_q - CNT_ONE;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                mem_q[i] <= INIT_TARGET;
            end
        end else if (wr_en) begin
            mem_q[wr_idx] <= push_target;
        end
    end

    assign ras_ret_target = mem_q[ptr_q];
    assign ras_index      = ptr_q;
    assign ras_count      = count_q;
    assign ras_empty      = cnt_zero;

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack; expectations follow the RAS_UNDERFLOW_PROTECT_EN build setting.
module tb_ras_stack;
    import core_types_pkg::*;

    logic                       CLK;
    logic                       RST;
    logic                       push_valid;
    ras_target_t                push_target;
    logic                       pop_valid;
    logic                       restore_valid;
    logic [RAS_INDEX_WIDTH-1:0] restore_index;
    logic [RAS_INDEX_WIDTH:0]   restore_count;
    ras_target_t                ras_ret_target;
    logic [RAS_INDEX_WIDTH-1:0] ras_index;
    logic [RAS_INDEX_WIDTH:0]   ras_count;
    logic                       ras_empty;

    int n_vec = 0;
    int n_err = 0;

    ras_stack dut (
        .CLK            (CLK),
        .RST            (RST),
        .push_valid     (push_valid),
        .push_target    (push_target),
        .pop_valid      (pop_valid),
        .restore_valid  (restore_valid),
        .restore_index  (restore_index),
        .restore_count  (restore_count),
        .ras_ret_target (ras_ret_target),
        .ras_index      (ras_index),
        .ras_count      (ras_count),
        .ras_empty      (ras_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] idx, input logic [31:0] cnt,
                             input logic [31:0] tgt);
        chk({tag, ".index"},  32'(ras_index),      idx);
        chk({tag, ".count"},  32'(ras_count),      cnt);
        chk({tag, ".target"}, 32'(ras_ret_target), tgt);
        chk({tag, ".empty"},  32'(ras_empty),      32'(cnt == 0));
    endtask

    // Inputs applied at the falling edge, captured at the rising edge, checked at the next fall.
    task automatic step(input logic p, input logic [31:0] t, input logic po);
        push_valid  = p;
        push_target = RAS_TARGET_WIDTH'(t);
        pop_valid   = po;
        @(posedge CLK);
        @(negedge CLK);
        push_valid  = 1'b0;
        pop_valid   = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b0; push_valid = 1'b0; push_target = '0; pop_valid = 1'b0;
        restore_valid = 1'b0; restore_index = '0; restore_count = '0;
        @(negedge CLK);
        do_reset();
        step(1'b0, 0, 1'b0);
        chk_state("reset", 0, 0, 0);

        // Pop on empty right after reset.
        step(1'b0, 0, 1'b1);
`ifdef RAS_UNDERFLOW_PROTECT_EN
        chk_state("pop_empty", 0, 0, 0);
`else
        chk_state("pop_empty", 7, 0, 0);
`endif

        // Pop+push on empty.
        do_reset();
        step(1'b1, 32'h5A, 1'b1);
`ifdef RAS_UNDERFLOW_PROTECT_EN
        chk_state("poppush_empty", 1, 1, 32'h5A);
`else
        chk_state("poppush_empty", 0, 0, 32'h5A);
`endif

        // Three pushes then two pops.
        do_reset();
        step(1'b1, 32'h100, 1'b0);
        step(1'b1, 32'h200, 1'b0);
        step(1'b1, 32'h300, 1'b0);
        chk_state("push3", 3, 3, 32'h300);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk_state("pop2", 1, 1, 32'h100);

        // Overflow: nine pushes wrap and saturate the count.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1'b1, 32'(i), 1'b0);
        chk_state("overflow", 1, 8, 32'h9);
        for (int i = 0; i < 7; i++) step(1'b0, 0, 1'b1);
        chk("drain.last_top", 32'(ras_ret_target), 32'h2);
        step(1'b0, 0, 1'b1);
        chk("drain.empty", 32'(ras_empty), 32'd1);
        chk("drain.count", 32'(ras_count), 32'd0);

        // Simultaneous pop+push replaces the top in place.
        do_reset();
        step(1'b1, 32'h11, 1'b0);
        step(1'b1, 32'hAB, 1'b0);
        chk_state("pre_pp", 2, 2, 32'hAB);
        step(1'b1, 32'hCD, 1'b1);
        chk_state("poppush", 2, 2, 32'hCD);

        // Restore beats a concurrent push; the array stays untouched.
        step(1'b1, 32'h33, 1'b0);
        step(1'b1, 32'h44, 1'b0);
        step(1'b1, 32'h55, 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1);
        chk_state("pre_restore", 2, 2, 32'hCD);
        restore_valid = 1'b1;
        restore_index = RAS_INDEX_WIDTH'(5);
        restore_count = (RAS_INDEX_WIDTH+1)'(4);
        step(1'b1, 32'h77, 1'b0);
        restore_valid = 1'b0;
        chk_state("restore", 5, 4, 32'h55);
        step(1'b0, 0, 1'b1);
        chk_state("post_restore1", 4, 3, 32'h44);
        step(1'b0, 0, 1'b1);
        chk_state("post_restore2", 3, 2, 32'h33);

        // Asynchronous reset between clock edges.
        #1;
        RST = 1'b1;
        #1;
        chk_state("async_rst", 0, 0, 0);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 0, 1'b0);
        chk_state("after_async", 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ras_stack.md
Name: ras_stack

Overview:
- Return address stack for the fetch predictor stage; the front end consumes its top-of-stack target when it predicts a return.
- Circular stack of RAS_ENTRIES return targets, each a PC[31:1] value.
- Pushed on predicted calls and popped on predicted returns.
- Its pointer and count are snapshotted by the front end at checkpoint and restored on branch mispredict.

Parameters:
- RAS_ENTRIES, 8, stack depth (power of 2).
- RAS_INDEX_WIDTH, $clog2(RAS_ENTRIES), width of the stack pointer.
- RAS_TARGET_WIDTH, 31, stored target width (PC[31:1]).
- INIT_PC, 32'h0, reset value; entries reset to INIT_PC[31:1].

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, asynchronous, active-high.
- push_valid  input  1  predicted call: push push_target.
- push_target  input  RAS_TARGET_WIDTH  return address PC[31:1].
- pop_valid  input  1  predicted return: pop the top of stack.
- restore_valid  input  1  mispredict restore of pointer and count.
- restore_index  input  RAS_INDEX_WIDTH  checkpointed stack pointer.
- restore_count  input  RAS_INDEX_WIDTH+1  checkpointed occupancy.
- ras_ret_target  output  RAS_TARGET_WIDTH  entry at the current pointer (combinational read).
- ras_index  output  RAS_INDEX_WIDTH  current pointer, snapshotted at checkpoint.
- ras_count  output  RAS_INDEX_WIDTH+1  current occupancy, 0..RAS_ENTRIES.
- ras_empty  output  1  ras_count==0.

Behaviour:
- State: array[RAS_ENTRIES] of targets; ptr (index of top); count.
- Reset (async, RST=1): ptr=0, count=0, all entries=INIT_PC[31:1]. Resulting outputs: ras_index=0, ras_count=0, ras_empty=1, ras_ret_target=0.
- Reads are combinational: ras_ret_target = array[ptr].
- All updates take effect at the next rising CLK edge. A push is visible on ras_ret_target in the following cycle.
- Priority: restore > push/pop.
  - restore_valid=1: ptr<=restore_index, count<=restore_count. push/pop are ignored and array contents are unchanged.
- push only: ptr<=ptr+1, wrapping modulo RAS_ENTRIES; array[ptr+1]<=push_target; count<=min(count+1, RAS_ENTRIES).
  - Overflow overwrites the oldest entry silently; count saturates.
- pop only: ptr<=ptr-1, wrapping (0 -> RAS_ENTRIES-1); count<=count-1 (underflow handling: see Optional Feature).
- push and pop together (jalr pop-then-push): array[ptr]<=push_target; ptr and count unchanged.
- Neither valid: hold.
- restore_count above RAS_ENTRIES is illegal input; the verification engineer asserts against it.
- RST asserted mid-operation clears state immediately, regardless of CLK.

Optional Feature:
- Macro RAS_UNDERFLOW_PROTECT_EN.
- Defined:
  - pop with count==0 leaves ptr and count unchanged, so the stale top is still predicted.
  - pop+push with count==0 behaves as push only.
- Undefined:
  - pop always decrements ptr (wrapping); count floors at 0.
  - pop+push with count==0 writes in place; count stays 0.
- In both builds, ras_empty reflects count.

Decomposition:
- Add to core_types_pkg: RAS_ENTRIES, RAS_INDEX_WIDTH, RAS_TARGET_WIDTH (already present) and INIT_PC.
- Add a typedef ras_target_t = logic [RAS_TARGET_WIDTH-1:0] to the same package.
- No sub-module: a single flat module with the array and pointer logic. Pointer next-state is a small always_comb block.

Test Plan:
- Reset, then idle → ras_index=0, ras_count=0, ras_empty=1, ras_ret_target=0.
- Push 31'h100, 31'h200, 31'h300 on consecutive cycles → ras_index=3, ras_count=3, ras_ret_target=31'h300. Then two pops → ras_index=1, ras_ret_target=31'h100, ras_count=1.
- 9 pushes of 31'h1..31'h9 → ras_count saturates at 8, ras_index=1 (wrapped), ras_ret_target=31'h9. Then 8 pops → last popped target is 31'h2 and ras_empty=1.
- With ptr=2, count=2, top=31'hAB: push 31'hCD and pop in the same cycle → ras_index=2, ras_count=2, ras_ret_target=31'hCD.
- Restore together with push: restore_valid=1, restore_index=5, restore_count=4, push_valid=1 → ras_index=5, ras_count=4, no array write (ras_ret_target = prior array[5]).
- Pop on empty after reset:
  - RAS_UNDERFLOW_PROTECT_EN defined → ras_index=0, ras_count=0.
  - Undefined → ras_index=7, ras_count=0.
